// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer: command opcodes, FSM states
// and status register bit positions.
package capture_sequencer_pkg;

  localparam logic [7:0] OP_START_SINGLE = 8'hD2;
  localparam logic [7:0] OP_START_CONT   = 8'hA2;
  localparam logic [7:0] OP_ABORT        = 8'h81;
  localparam logic [7:0] OP_CLR_ERR      = 8'h85;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ARMED,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  localparam int unsigned STAT_BUSY      = 7;
  localparam int unsigned STAT_CONT      = 6;
  localparam int unsigned STAT_ERR_LEN   = 5;
  localparam int unsigned STAT_ERR_SHORT = 4;
  localparam int unsigned STAT_ERR_BUSY  = 3;

  function automatic logic is_start(input logic [7:0] op);
    return (op == OP_START_SINGLE) || (op == OP_START_CONT);
  endfunction

endpackage

// File: rtl/capture_sequencer_edge_det.sv
// Edge detector: registers the previous input sample and flags rising and
// falling transitions against it in the cycle the new level is seen.
module capture_sequencer_edge_det (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge res) begin
    if (!res) prev_q <= 1'b0;
    else      prev_q <= d;
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: decodes SPI commands, locks onto a whole camera frame,
// issues frame-store write enables with byte/line coordinates and keeps a
// sticky error and frame-count status register.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned PIX_BYTES = 1280,
  parameter int unsigned LINES     = 480,
  parameter int unsigned XW        = 11,
  parameter int unsigned YW        = 9
) (
  input  logic          clk,
  input  logic          res,
  input  logic          vsync,
  input  logic          href,
  input  logic          pix_stb,
  input  logic [7:0]    cmd_byte,
  input  logic          cmd_valid,
  output logic          cap_en,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_done,
  output logic          busy,
  output logic [7:0]    status
);

  localparam logic [XW-1:0] PIX_MAX   = XW'(PIX_BYTES);
  localparam logic [YW-1:0] LINES_MAX = YW'(LINES);

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  state_e        state_q, state_d;
  logic          cont_q, cont_d;
  logic          cap_en_q, cap_en_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          err_len_q, err_len_d;
  logic          err_short_q, err_short_d;
  logic          err_busy_q, err_busy_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [XW-1:0] xcnt_q, xcnt_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic [YW-1:0] pix_y_q, pix_y_d;

  logic          op_start, op_abort, op_clr;
  logic [XW-1:0] xcur;

  capture_sequencer_edge_det u_vsync_edge (
    .clk  (clk),
    .res  (res),
    .d    (vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  capture_sequencer_edge_det u_href_edge (
    .clk  (clk),
    .res  (res),
    .d    (href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  assign op_start = cmd_valid && is_start(cmd_byte);
  assign op_abort = cmd_valid && (cmd_byte == OP_ABORT);
  assign op_clr   = cmd_valid && (cmd_byte == OP_CLR_ERR);

  // Next-state, counter, capture and error logic.
  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    cap_en_d     = 1'b0;
    frame_done_d = 1'b0;
    err_len_d    = err_len_q;
    err_short_d  = err_short_q;
    err_busy_d   = err_busy_q;
    frame_cnt_d  = frame_cnt_q;
    xcnt_d       = xcnt_q;
    ycnt_d       = ycnt_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    // A byte arriving with the href rising edge is byte 0 of the new line.
    xcur         = hr_rise ? '0 : xcnt_q;

    // Clear first so that an error raised in the same cycle survives.
    if (op_clr) begin
      err_len_d   = 1'b0;
      err_short_d = 1'b0;
      err_busy_d  = 1'b0;
    end
    if (op_start && (state_q != ST_IDLE)) err_busy_d = 1'b1;

    if (op_abort) begin
      state_d = ST_IDLE;
      cont_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            state_d = ST_SYNC;
            cont_d  = (cmd_byte == OP_START_CONT);
          end
        end
        ST_SYNC: begin
          if (vsync) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (vs_fall) begin
            state_d = ST_ACTIVE;
            xcnt_d  = '0;
            ycnt_d  = '0;
            pix_y_d = '0;
          end
        end
        ST_ACTIVE: begin
          if (hr_rise) xcnt_d = '0;
          if (pix_stb && href) begin
            if ((xcur < PIX_MAX) && (ycnt_q < LINES_MAX)) begin
              cap_en_d = 1'b1;
              pix_x_d  = xcur;
              pix_y_d  = ycnt_q;
              xcnt_d   = xcur + 1'b1;
            end else begin
              err_len_d = 1'b1;
            end
          end
          if (hr_fall && (ycnt_q < LINES_MAX)) ycnt_d = ycnt_q + 1'b1;
          if (vs_rise) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            if (ycnt_q < LINES_MAX) err_short_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = cont_q ? ST_ARMED : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      cont_q       <= 1'b0;
      cap_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_len_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_busy_q   <= 1'b0;
      frame_cnt_q  <= '0;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      cap_en_q     <= cap_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_len_q    <= err_len_d;
      err_short_q  <= err_short_d;
      err_busy_q   <= err_busy_d;
      frame_cnt_q  <= frame_cnt_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
    end
  end

  // Status word assembled from the registered flags.
  always_comb begin
    status                 = '0;
    status[STAT_BUSY]      = busy_q;
    status[STAT_CONT]      = cont_q;
    status[STAT_ERR_LEN]   = err_len_q;
    status[STAT_ERR_SHORT] = err_short_q;
    status[STAT_ERR_BUSY]  = err_busy_q;
    status[2:0]            = frame_cnt_q[2:0];
  end

  assign cap_en     = cap_en_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
